// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes common with the
// ALU controller, the FSM state type and the default datapath width.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    // The shift-add multiplier retires one multiplier bit per cycle.
    localparam int MUL_STEPS  = ALU_DATA_W;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier: one partial-product step per cycle, done
// strobes on the final step with the completed product on product_o.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int STEPS = DATA_W;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] acc_step;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) busy_d = 1'b0;
        end
    end

    // NOTE: datapath registers are reset too, so an aborted multiply leaves no stale state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == LAST_STEP);
    assign product_o = acc_step;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, iterative MUL, and a
// registered result/zero/valid under a valid/ready handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ALUctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              valid_o
);

    alu_state_e        state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              valid_q, valid_d;
    logic              accept;
    logic              mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [DATA_W-1:0] simple_res;

    assign ready_o = (state_q == ST_IDLE);
    assign accept  = valid_i && ready_o;

    alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (src1_i),
        .b_i       (src2_i),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        case (ALUctrl_i)
            ALU_AND: simple_res = src1_i & src2_i;
            ALU_OR:  simple_res = src1_i | src2_i;
            ALU_ADD: simple_res = src1_i + src2_i;
            ALU_SUB: simple_res = src1_i - src2_i;
            ALU_SLT: simple_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: simple_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && ALUctrl_i == ALU_MUL) state_d = ST_MUL;
            // Leaving on !mul_busy as well keeps the FSM from wedging if the two ever disagree.
            ST_MUL:  if (mul_done || !mul_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mul_start = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ALUctrl_i == ALU_MUL) begin
                        mul_start = 1'b1;
                    end else begin
                        result_d = simple_res;
                        zero_d   = (simple_res == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                    valid_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign valid_o  = valid_q;

endmodule
